// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Definitions shared by the pipeline stage: occupancy width, the default control
// value driven while no entry is presented, the standard MEM/WB control bit
// positions, and a helper that turns the two entry valid bits into a count.
// No ports.
// -----------------------------------------------------------------------------
package pipe_pkg;

  localparam int OCC_W          = 2;
  localparam int CTRL_W_DEFAULT = 8;

  // Control word driven while the stage presents no valid entry.
  localparam logic [CTRL_W_DEFAULT-1:0] CTRL_RST_DEFAULT = 8'h00;

  // Standard MEM/WB control bit positions inside the control payload.
  localparam int REGWRITE_BIT = 0;
  localparam int MEMTOREG_BIT = 1;
  localparam int WRITER7_BIT  = 2;
  localparam int HALT_BIT     = 3;
  localparam int WRSEL_LSB    = 4;

  typedef logic [OCC_W-1:0] occ_t;

  // Number of held entries given the main and skid valid bits.
  function automatic occ_t occCount(input logic mainV, input logic skidV);
    occCount = {1'b0, mainV} + {1'b0, skidV};
  endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// -----------------------------------------------------------------------------
// pipe_entry_reg
// One {valid, data, ctrl} holding register used for both the main and the skid
// entry of pipe_stage_skid.
// Ports:
//   clk       clock
//   rst       synchronous reset, active-low (clears valid, data and ctrl)
//   load      capture loadData/loadCtrl and mark the entry valid
//   clear     mark the entry invalid; data and ctrl keep their last value
//   loadData  data payload to capture
//   loadCtrl  control payload to capture
//   valid     entry holds a live payload
//   data      held data payload
//   ctrl      held control payload
// clear has priority over load.
// -----------------------------------------------------------------------------
module pipe_entry_reg #(
  parameter int DATA_W = 48,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] loadData,
  input  logic [CTRL_W-1:0] loadCtrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  // Entry state register: reset, then clear, then load, else hold.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid <= 1'b0;
      data  <= '0;
      ctrl  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= loadData;
      ctrl  <= loadCtrl;
    end else begin
      valid <= valid;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
// Inter-stage pipeline register with a valid/ready handshake and a 2-entry skid
// buffer. in_ready comes straight from a register, so there is no combinational
// path from out_ready to in_ready.
// Optional build macro: PIPE_STAGE_PERF_EN adds stall/bubble counters.
// Ports:
//   clk, rst              clock; synchronous active-low reset
//   in_valid/in_ready     upstream handshake (in_ready = !skid valid)
//   data_in, ctrl_in      upstream payload, captured only on push
//   flush                 drop all held entries and this cycle's push
//   out_valid/out_ready   downstream handshake
//   data_out              main data, holds last value when invalid
//   ctrl_out              main control, CTRL_RST when invalid
//   occupancy             held entries, 0..2
//   stall_cnt             (PIPE_STAGE_PERF_EN) cycles with out_valid & !out_ready
//   bubble_cnt            (PIPE_STAGE_PERF_EN) cycles with !out_valid
// -----------------------------------------------------------------------------
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                DATA_W   = 48,
  parameter int                CTRL_W   = CTRL_W_DEFAULT,
  parameter logic [CTRL_W-1:0] CTRL_RST = CTRL_W'(CTRL_RST_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [OCC_W-1:0]  occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       bubble_cnt
`endif
);

  logic              mainValid, skidValid;
  logic [DATA_W-1:0] mainData, skidData;
  logic [CTRL_W-1:0] mainCtrl, skidCtrl;

  logic              push_s, pop_s, mainFree_s;
  logic              mainLoad_s, mainClear_s, skidLoad_s, skidClear_s;
  logic [DATA_W-1:0] mainSrcData_s;
  logic [CTRL_W-1:0] mainSrcCtrl_s;

  // Handshake decode and load/clear steering for the two entries.
  always_comb begin
    push_s      = in_valid & in_ready;
    pop_s       = mainValid & out_ready;
    mainFree_s  = !mainValid | pop_s;
    mainLoad_s  = 1'b0;
    mainClear_s = 1'b0;
    skidLoad_s  = 1'b0;
    skidClear_s = 1'b0;
    if (flush) begin
      mainClear_s = 1'b1;
      skidClear_s = 1'b1;
    end else if (mainFree_s) begin
      // Main refills from skid first (FIFO order), else from the push.
      if (skidValid | push_s) begin
        mainLoad_s = 1'b1;
      end else begin
        mainClear_s = 1'b1;
      end
      if (skidValid) begin
        if (push_s) begin
          skidLoad_s = 1'b1;
        end else begin
          skidClear_s = 1'b1;
        end
      end else begin
        skidLoad_s = 1'b0;
      end
    end else begin
      // Main is held: an accepted push parks in skid.
      if (push_s) begin
        skidLoad_s = 1'b1;
      end else begin
        skidLoad_s = 1'b0;
      end
    end
  end

  // Main entry source: the older skid entry always wins over new input.
  always_comb begin
    if (skidValid) begin
      mainSrcData_s = skidData;
      mainSrcCtrl_s = skidCtrl;
    end else begin
      mainSrcData_s = data_in;
      mainSrcCtrl_s = ctrl_in;
    end
  end

  pipe_entry_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) mainEntry (
    .clk      (clk),
    .rst      (rst),
    .load     (mainLoad_s),
    .clear    (mainClear_s),
    .loadData (mainSrcData_s),
    .loadCtrl (mainSrcCtrl_s),
    .valid    (mainValid),
    .data     (mainData),
    .ctrl     (mainCtrl)
  );

  pipe_entry_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) skidEntry (
    .clk      (clk),
    .rst      (rst),
    .load     (skidLoad_s),
    .clear    (skidClear_s),
    .loadData (data_in),
    .loadCtrl (ctrl_in),
    .valid    (skidValid),
    .data     (skidData),
    .ctrl     (skidCtrl)
  );

  assign in_ready  = !skidValid;
  assign out_valid = mainValid;
  assign data_out  = mainData;
  assign ctrl_out  = mainValid ? mainCtrl : CTRL_RST;
  assign occupancy = occCount(mainValid, skidValid);

`ifdef PIPE_STAGE_PERF_EN
  // Saturating stall/bubble counters, cleared by reset or flush.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      stall_cnt  <= 16'h0000;
      bubble_cnt <= 16'h0000;
    end else begin
      if (mainValid && !out_ready && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'h0001;
      end else begin
        stall_cnt <= stall_cnt;
      end
      if (!mainValid && (bubble_cnt != 16'hFFFF)) begin
        bubble_cnt <= bubble_cnt + 16'h0001;
      end else begin
        bubble_cnt <= bubble_cnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_skid
// Directed bench for pipe_stage_skid: reset, streaming, backpressure, push/pop
// at occupancy 1 after full, flush, and (with PIPE_STAGE_PERF_EN) the counters.
// Inputs change 1 time unit after the rising edge; outputs are checked there.
// -----------------------------------------------------------------------------
module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] data_in;
  logic [7:0]  ctrl_in;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] data_out;
  logic [7:0]  ctrl_out;
  logic [1:0]  occupancy;
`ifdef PIPE_STAGE_PERF_EN
  logic [15:0] stall_cnt;
  logic [15:0] bubble_cnt;
`endif

  int nCompared = 0;
  int nFailed   = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(48), .CTRL_W(8), .CTRL_RST(8'h00)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .ctrl_in   (ctrl_in),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .ctrl_out  (ctrl_out),
    .occupancy (occupancy)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .bubble_cnt(bubble_cnt)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nFailed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic v, input logic [47:0] d, input logic [7:0] c);
    in_valid = v;
    data_in  = d;
    ctrl_in  = c;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
    offer(1'b1, 48'h123, 8'hFF);

    // Reset held two cycles with an offered entry.
    step(); step();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_occ", occupancy, 2'd0);
    check("rst_ctrl", ctrl_out, 8'h00);
    check("rst_data", data_out, 48'h0);

    // Streaming with out_ready=1.
    rst = 1'b1; out_ready = 1'b1;
    offer(1'b1, 48'h1, 8'h11);
    step();
    check("str1_valid", out_valid, 1'b1);
    check("str1_data", data_out, 48'h1);
    check("str1_ctrl", ctrl_out, 8'h11);
    check("str1_occ", occupancy, 2'd1);
    check("str1_ready", in_ready, 1'b1);
    offer(1'b1, 48'h2, 8'h22);
    step();
    check("str2_data", data_out, 48'h2);
    check("str2_occ", occupancy, 2'd1);
    offer(1'b1, 48'h3, 8'h33);
    step();
    check("str3_data", data_out, 48'h3);
    check("str3_ready", in_ready, 1'b1);
    offer(1'b0, 48'h0, 8'h00);
    step();
    check("str_end_valid", out_valid, 1'b0);
    check("str_end_ctrl", ctrl_out, 8'h00);
    check("str_end_hold", data_out, 48'h3);
    check("str_end_occ", occupancy, 2'd0);

    // Backpressure: fill, drop third, drain.
    out_ready = 1'b0;
    offer(1'b1, 48'hA, 8'hAA);
    step();
    check("bp_a_occ", occupancy, 2'd1);
    check("bp_a_data", data_out, 48'hA);
    offer(1'b1, 48'hB, 8'hBB);
    step();
    check("bp_full_occ", occupancy, 2'd2);
    check("bp_full_ready", in_ready, 1'b0);
    check("bp_full_data", data_out, 48'hA);
    offer(1'b1, 48'hC, 8'hCC);
    step();
    check("bp_drop_occ", occupancy, 2'd2);
    check("bp_drop_data", data_out, 48'hA);
    offer(1'b0, 48'h0, 8'h00);
    out_ready = 1'b1;
    step();
    check("bp_pop1_data", data_out, 48'hB);
    check("bp_pop1_ctrl", ctrl_out, 8'hBB);
    check("bp_pop1_ready", in_ready, 1'b1);
    check("bp_pop1_occ", occupancy, 2'd1);
    step();
    check("bp_pop2_valid", out_valid, 1'b0);
    check("bp_pop2_occ", occupancy, 2'd0);

    // Fill again, then pop with push at occupancy 1: order A, B, D.
    out_ready = 1'b0;
    offer(1'b1, 48'hA, 8'hAA);
    step();
    offer(1'b1, 48'hB, 8'hBB);
    step();
    check("sim_full_occ", occupancy, 2'd2);
    check("sim_full_head", data_out, 48'hA);
    offer(1'b0, 48'h0, 8'h00);
    out_ready = 1'b1;
    step();
    check("sim_b_data", data_out, 48'hB);
    check("sim_b_ready", in_ready, 1'b1);
    offer(1'b1, 48'hD, 8'hDD);
    step();
    check("sim_d_data", data_out, 48'hD);
    check("sim_d_ctrl", ctrl_out, 8'hDD);
    check("sim_d_occ", occupancy, 2'd1);
    offer(1'b0, 48'h0, 8'h00);
    step();
    check("sim_empty_valid", out_valid, 1'b0);

    // Flush at full with 0xE offered.
    out_ready = 1'b0;
    offer(1'b1, 48'hA, 8'hAA);
    step();
    offer(1'b1, 48'hB, 8'hBB);
    step();
    check("fl_full_occ", occupancy, 2'd2);
    flush = 1'b1;
    offer(1'b1, 48'hE, 8'hEE);
    step();
    check("fl_valid", out_valid, 1'b0);
    check("fl_occ", occupancy, 2'd0);
    check("fl_ctrl", ctrl_out, 8'h00);
    check("fl_ready", in_ready, 1'b1);
    check("fl_data_kept", data_out, 48'hA);
    flush = 1'b0;
    offer(1'b0, 48'h0, 8'h00);
    step();
    check("fl_no_e_valid", out_valid, 1'b0);

    // Flush at occupancy 1 while a push is actually accepted: push dropped.
    offer(1'b1, 48'hF, 8'h0F);
    step();
    check("fl1_occ", occupancy, 2'd1);
    flush = 1'b1;
    offer(1'b1, 48'hE, 8'hEE);
    step();
    check("fl1_occ_after", occupancy, 2'd0);
    check("fl1_data_kept", data_out, 48'hF);
    flush = 1'b0;
    offer(1'b0, 48'h0, 8'h00);
    step();
    check("fl1_no_e_valid", out_valid, 1'b0);
    check("fl1_no_e_data", data_out, 48'hF);

`ifdef PIPE_STAGE_PERF_EN
    // Counters: zero by flush, load one entry (that edge sees an empty
    // stage, one bubble), stall 5 cycles, drain, then 3 empty cycles.
    out_ready = 1'b0;
    flush = 1'b1;
    step();
    check("perf_clr_stall", stall_cnt, 16'd0);
    check("perf_clr_bubble", bubble_cnt, 16'd0);
    flush = 1'b0;
    offer(1'b1, 48'h5, 8'h55);
    step();
    offer(1'b0, 48'h0, 8'h00);
    repeat (5) step();
    check("perf_stall5", stall_cnt, 16'd5);
    check("perf_bubble1", bubble_cnt, 16'd1);
    out_ready = 1'b1;
    step();
    repeat (3) step();
    check("perf_bubble_plus3", bubble_cnt, 16'd4);
    check("perf_stall_hold", stall_cnt, 16'd5);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("perf_fl_stall", stall_cnt, 16'd0);
    check("perf_fl_bubble", bubble_cnt, 16'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule
